// File: rtl/booth_pkg.sv
// Shared constants and state encoding for the Booth dot-product stage.
package booth_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;
    localparam int CNT_W  = 8;

    // Bit index of the product sign, used when widening into the accumulator.
    localparam int PROD_SIGN_BIT = PROD_W - 1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/booth_dot_acc_if.sv
// Operand-in / result-out handshake bundle for booth_dot_acc.
interface booth_dot_acc_if #(
    parameter int ACC_W = 12
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic signed [booth_pkg::OPND_W-1:0]  a;
    logic signed [booth_pkg::OPND_W-1:0]  b;
    logic                                 out_valid;
    logic                                 out_ready;
    logic        [ACC_W-1:0]              out_sum;
    logic                                 out_ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/booth_main.sv
// Combinational radix-2 Booth multiplier, 4-bit signed operands, 8-bit signed product.
module booth_main
    import booth_pkg::*;
(
    input  logic signed [OPND_W-1:0] a,
    input  logic signed [OPND_W-1:0] b,
    output logic signed [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] a_ext;
    logic [OPND_W:0]   b_pair;

    always_comb begin
        a_ext  = PROD_W'(a);
        b_pair = {b, 1'b0};
        prod   = '0;
        // Each adjacent bit pair (b[i], b[i-1]) selects +a, -a or nothing at weight 2^i.
        for (int i = 0; i < OPND_W; i++) begin
            case (b_pair[i+1 -: 2])
                2'b01:   prod = prod + (a_ext << i);
                2'b10:   prod = prod - (a_ext << i);
                default: prod = prod;
            endcase
        end
    end

endmodule

// File: rtl/booth_dot_acc.sv
// Streaming dot product: accepts N_TERMS operand pairs, accumulates their Booth products,
// and presents the signed sum with a sticky overflow flag.
module booth_dot_acc
    import booth_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input logic           clk,
    input logic           rst,
    booth_dot_acc_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_r;
    logic                     prod_v;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         acc_sum;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_r;
    logic                     add_ovf;
    logic                     accept;
    logic                     out_fire;
    logic                     last_term;

    booth_main u_mult (
        .a    (bus.a),
        .b    (bus.b),
        .prod (prod_c)
    );

    // Handshake terms derive from state directly so in_ready never depends on out_ready.
    assign accept    = bus.in_valid && (state == ACCUM);
    assign out_fire  = bus.out_ready && (state == OUT);
    assign last_term = (cnt == CNT_W'(N_TERMS - 1));

    assign prod_ext = ACC_W'(prod_r);
    assign acc_sum  = acc + prod_ext;
    assign add_ovf  = (acc[ACC_W-1] == prod_r[PROD_SIGN_BIT]) &&
                      (acc_sum[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_ovf   = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (accept && last_term) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_sum   = acc;
                bus.out_ovf   = ovf_r;
                if (out_fire) begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_r <= prod_c;
            end
            if (out_fire) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            // prod_v is never set in OUT, so the clear and the add cannot collide.
            if (out_fire) begin
                acc   <= '0;
                ovf_r <= 1'b0;
            end else if (prod_v) begin
                acc <= acc_sum;
                if (add_ovf) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_dot_acc.sv
// Directed bench: two instances (ACC_W=12 and ACC_W=8) driven by the same stimulus.
module tb_booth_dot_acc;

    logic clk;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic signed [3:0] a;
    logic signed [3:0] b;

    int n_checks;
    int n_pass;

    booth_dot_acc_if #(.ACC_W(12)) if12 ();
    booth_dot_acc_if #(.ACC_W(8))  if8 ();

    assign if12.in_valid  = in_valid;
    assign if12.out_ready = out_ready;
    assign if12.a         = a;
    assign if12.b         = b;
    assign if8.in_valid   = in_valid;
    assign if8.out_ready  = out_ready;
    assign if8.a          = a;
    assign if8.b          = b;

    booth_dot_acc #(.N_TERMS(4), .ACC_W(12)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (if12)
    );

    booth_dot_acc #(.N_TERMS(4), .ACC_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic send(input logic signed [3:0] ta, input logic signed [3:0] tb_v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        while (if12.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (if12.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk(tag, 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_in_ready",  32'(if12.in_ready), 1);
        chk("rst_out_valid", 32'(if12.out_valid), 0);
        chk("rst_out_sum",   $signed(if12.out_sum), 0);
        chk("rst_out_ovf",   32'(if12.out_ovf), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mixed-sign back-to-back terms, latency and restart timing.
        send(3, 2);
        send(-3, 2);
        send(4, -3);
        send(7, 7);
        chk("lat_drain_valid", 32'(if12.out_valid), 0);
        chk("lat_drain_ready", 32'(if12.in_ready), 0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 32'(if12.out_valid), 1);
        chk("mix_sum12", $signed(if12.out_sum), 37);
        chk("mix_ovf12", 32'(if12.out_ovf), 0);
        chk("mix_sum8",  $signed(if8.out_sum), 37);
        chk("mix_ovf8",  32'(if8.out_ovf), 0);
        handshake();
        chk("restart_ready", 32'(if12.in_ready), 1);
        chk("restart_valid", 32'(if12.out_valid), 0);

        // Most-negative operands.
        for (int i = 0; i < 4; i++) send(-8, -8);
        wait_out("neg_timeout");
        chk("neg_sum12", $signed(if12.out_sum), 256);
        chk("neg_ovf12", 32'(if12.out_ovf), 0);
        chk("neg_sum8",  $signed(if8.out_sum), 0);
        chk("neg_ovf8",  32'(if8.out_ovf), 1);
        handshake();

        // Overflow on the 8-bit accumulator, then flag cleared on the next dot product.
        for (int i = 0; i < 4; i++) send(7, 7);
        wait_out("ovf_timeout");
        chk("ovf_sum8",  $signed(if8.out_sum), -60);
        chk("ovf_ovf8",  32'(if8.out_ovf), 1);
        chk("ovf_sum12", $signed(if12.out_sum), 196);
        chk("ovf_ovf12", 32'(if12.out_ovf), 0);
        handshake();
        for (int i = 0; i < 4; i++) send(0, -7);
        wait_out("clr_timeout");
        chk("clr_sum8", $signed(if8.out_sum), 0);
        chk("clr_ovf8", 32'(if8.out_ovf), 0);
        handshake();

        // Backpressure with input held valid.
        for (int i = 0; i < 4; i++) send(2, 3);
        wait_out("bp_timeout");
        in_valid = 1'b1;
        a        = 4'sd1;
        b        = 4'sd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready",  32'(if12.in_ready), 0);
            chk("bp_out_valid", 32'(if12.out_valid), 1);
            chk("bp_out_sum",   $signed(if12.out_sum), 24);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_after_valid", 32'(if12.out_valid), 0);
        chk("bp_after_ready", 32'(if12.in_ready), 1);

        // Gapped input: idle cycles must not count as terms.
        send(1, 1);
        @(posedge clk);
        #1;
        send(2, 2);
        @(posedge clk);
        #1;
        send(3, 3);
        @(posedge clk);
        #1;
        chk("gap_still_accum", 32'(if12.in_ready), 1);
        send(-4, -4);
        wait_out("gap_timeout");
        chk("gap_sum12", $signed(if12.out_sum), 30);
        handshake();

        // Asynchronous reset mid dot product.
        send(5, 5);
        send(5, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_in_ready",  32'(if12.in_ready), 1);
        chk("rstmid_out_valid", 32'(if12.out_valid), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 1);
        wait_out("rstmid_timeout");
        chk("rstmid_sum12", $signed(if12.out_sum), 4);
        chk("rstmid_ovf12", 32'(if12.out_ovf), 0);

        // Asynchronous reset while holding a result in OUT.
        #2;
        rst = 1'b1;
        #1;
        chk("rstout_out_valid", 32'(if12.out_valid), 0);
        chk("rstout_in_ready",  32'(if12.in_ready), 1);
        chk("rstout_out_sum",   $signed(if12.out_sum), 0);
        chk("rstout_out_ovf",   32'(if12.out_ovf), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(-1, 3);
        wait_out("post_rst_timeout");
        chk("post_rst_sum12", $signed(if12.out_sum), -12);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
